// File: rtl/btn_conditioner.sv
// Button/joystick input conditioner: sync, debounce, polarity-normalise, press/release/long strobes.
// Optional auto-repeat of press_pulse on REPEAT_MASK channels when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
  parameter int unsigned      N_BTN           = 6,
  parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = 6'b001000,
  parameter int unsigned      DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned      LONG_CYCLES     = 250000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 6'b110000,
  parameter int unsigned      REPEAT_DELAY    = 25000000,
  parameter int unsigned      REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] long_held
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  // hold_cnt lands on LONG_CYCLES-1 in the same cycle long_pulse is seen
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    LONG      = 3'd3,
    DEB_REL   = 3'd4
  } state_t;

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;

  // Normalise to active-high, then two-flop synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw ^ ACTIVE_LOW_MASK;
      sync_q2 <= sync_q1;
    end
  end

`ifndef BTN_AUTOREPEAT_EN
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_MASK, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pressed_q, pressed_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              long_held_q, long_held_d;
    logic              rep_fire_c;
    logic              s;

    assign s = sync_q2[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q     <= IDLE;
        deb_q       <= '0;
        hold_q      <= '0;
        pressed_q   <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        long_held_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        deb_q       <= deb_d;
        hold_q      <= hold_d;
        pressed_q   <= pressed_d;
        press_q     <= press_d | rep_fire_c;
        release_q   <= release_d;
        long_q      <= long_d;
        long_held_q <= long_held_d;
      end
    end

    // Channel FSM: debounce both edges, time the hold, freeze hold_cnt while release is pending
    always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      pressed_d   = pressed_q;
      long_held_d = long_held_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s) begin
            state_d = DEB_PRESS;
            deb_d   = DEB_W'(1);
          end
        end
        DEB_PRESS: begin
          if (!s) begin
            state_d = IDLE;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d   = HELD;
            deb_d     = '0;
            hold_d    = '0;
            pressed_d = 1'b1;
            press_d   = 1'b1;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state_d = DEB_REL;
            deb_d   = DEB_W'(1);
          end else begin
            hold_d = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_LAST) begin
              state_d     = LONG;
              long_d      = 1'b1;
              long_held_d = 1'b1;
            end
          end
        end
        LONG: begin
          if (!s) begin
            state_d = DEB_REL;
            deb_d   = DEB_W'(1);
          end
        end
        DEB_REL: begin
          if (s) begin
            state_d = long_held_q ? LONG : HELD;
            deb_d   = '0;
          end else if (deb_q == DEB_LAST) begin
            state_d     = IDLE;
            deb_d       = '0;
            hold_d      = '0;
            pressed_d   = 1'b0;
            long_held_d = 1'b0;
            release_d   = 1'b1;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          deb_d   = '0;
          hold_d  = '0;
        end
      endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int unsigned REP_W   = $clog2(REP_MAX) + 1;

      logic [REP_W-1:0] rep_q, rep_d;
      logic             first_q, first_d;
      logic             fire_c;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rep_q   <= '0;
          first_q <= 1'b1;
        end else begin
          rep_q   <= rep_d;
          first_q <= first_d;
        end
      end

      // Counts cycles since the last press strobe; paused while a release is being debounced
      always_comb begin
        rep_d   = rep_q;
        first_d = first_q;
        fire_c  = 1'b0;
        if (state_q == IDLE || state_q == DEB_PRESS) begin
          rep_d   = '0;
          first_d = 1'b1;
        end else if ((state_q == HELD || state_q == LONG) && s) begin
          if (rep_q == (first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1))) begin
            fire_c  = 1'b1;
            rep_d   = '0;
            first_d = 1'b0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
      end

      assign rep_fire_c = fire_c;
    end else begin : g_norep
      assign rep_fire_c = 1'b0;
    end
`else
    assign rep_fire_c = 1'b0;
`endif

    assign pressed[i]       = pressed_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_pulse[i]    = long_q;
    assign long_held[i]     = long_held_q;
  end

endmodule
